// File: rtl/rst_mon_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rst_mon_if : observed-reset, control and status bundle for rst_mon
// Revision   : 1.0
// ---------------------------------------------------------------------------
interface rst_mon_if #(
   parameter int CNT_W = 16
);
   logic             mon_rst_ni;
   logic             clr_i;
   logic             wait_req_i;
   logic [CNT_W-1:0] wait_cycles_i;
   logic             in_reset_o;
   logic [CNT_W-1:0] low_len_o;
   logic             low_len_valid_o;
   logic             short_err_o;
   logic [7:0]       rst_count_o;
   logic [31:0]      up_cycles_o;
   logic             wait_busy_o;
   logic             wait_ack_o;
   logic             wait_abort_o;

   modport master (
      output mon_rst_ni, clr_i, wait_req_i, wait_cycles_i,
      input  in_reset_o, low_len_o, low_len_valid_o, short_err_o,
             rst_count_o, up_cycles_o, wait_busy_o, wait_ack_o, wait_abort_o
   );

   modport slave (
      input  mon_rst_ni, clr_i, wait_req_i, wait_cycles_i,
      output in_reset_o, low_len_o, low_len_valid_o, short_err_o,
             rst_count_o, up_cycles_o, wait_busy_o, wait_ack_o, wait_abort_o
   );
endinterface
`default_nettype wire

// File: rtl/rst_mon.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rst_mon : measures observed reset pulses, counts them, and serves
//           abortable clock-count waits
// Revision: 1.0
// ---------------------------------------------------------------------------
module rst_mon #(
   parameter int MIN_LOW_CYCLES = 100,
   parameter int CNT_W          = 16
) (
   input  logic     clk,
   input  logic     rst_n,
   rst_mon_if.slave bus
);
   localparam logic [0:0]       S_UP    = 1'b0;
   localparam logic [0:0]       S_LOW   = 1'b1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] MIN_LEN = CNT_W'(MIN_LOW_CYCLES);

   logic [0:0]       state;
   logic [0:0]       state_nxt;
   logic             in_reset;
   logic             release_ev;
   logic [CNT_W-1:0] low_cnt;
   logic [CNT_W-1:0] low_len;
   logic             low_len_valid;
   logic             short_err;
   logic [7:0]       rst_count;
   logic [31:0]      up_cycles;
   logic [CNT_W-1:0] wait_cnt;
   logic             wait_busy;
   logic             wait_ack;
   logic             wait_abort;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_UP;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_UP:    if (!bus.mon_rst_ni) state_nxt = S_LOW;
         S_LOW:   if (bus.mon_rst_ni)  state_nxt = S_UP;
         default: state_nxt = S_UP;
      endcase
   end

   always_comb begin
      in_reset   = (state == S_LOW);
      release_ev = (state == S_LOW) && bus.mon_rst_ni;
   end

   // Pulse measurement; a set/increment on release takes priority over clr_i.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         low_cnt       <= '0;
         low_len       <= '0;
         low_len_valid <= 1'b0;
         short_err     <= 1'b0;
         rst_count     <= '0;
         up_cycles     <= '0;
      end else begin
         low_len_valid <= 1'b0;
         if (state == S_UP) begin
            if (!bus.mon_rst_ni) low_cnt <= CNT_ONE;
         end else if (!bus.mon_rst_ni && low_cnt != CNT_MAX) begin
            low_cnt <= low_cnt + CNT_ONE;
         end

         if (release_ev) begin
            low_len       <= low_cnt;
            low_len_valid <= 1'b1;
         end

         if (release_ev && low_cnt < MIN_LEN) short_err <= 1'b1;
         else if (bus.clr_i)                  short_err <= 1'b0;

         if (release_ev) begin
            if (rst_count != 8'hFF) rst_count <= rst_count + 8'd1;
         end else if (bus.clr_i) begin
            rst_count <= '0;
         end

         if (release_ev)                                 up_cycles <= '0;
         else if (state == S_UP && up_cycles != 32'hFFFF_FFFF) up_cycles <= up_cycles + 32'd1;
      end
   end

   // wait_cnt holds the cycles still to go before the ack cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wait_cnt   <= '0;
         wait_busy  <= 1'b0;
         wait_ack   <= 1'b0;
         wait_abort <= 1'b0;
      end else begin
         wait_ack   <= 1'b0;
         wait_abort <= 1'b0;
         if (wait_busy) begin
            if (!bus.mon_rst_ni) begin
               wait_busy  <= 1'b0;
               wait_ack   <= 1'b1;
               wait_abort <= 1'b1;
            end else if (wait_cnt == CNT_ONE) begin
               wait_busy <= 1'b0;
               wait_ack  <= 1'b1;
            end else begin
               wait_cnt <= wait_cnt - CNT_ONE;
            end
         end else if (bus.wait_req_i) begin
            if (!bus.mon_rst_ni) begin
               wait_ack   <= 1'b1;
               wait_abort <= 1'b1;
            end else if (bus.wait_cycles_i <= CNT_ONE) begin
               wait_ack <= 1'b1;
            end else begin
               wait_busy <= 1'b1;
               wait_cnt  <= bus.wait_cycles_i - CNT_ONE;
            end
         end
      end
   end

   assign bus.in_reset_o      = in_reset;
   assign bus.low_len_o       = low_len;
   assign bus.low_len_valid_o = low_len_valid;
   assign bus.short_err_o     = short_err;
   assign bus.rst_count_o     = rst_count;
   assign bus.up_cycles_o     = up_cycles;
   assign bus.wait_busy_o     = wait_busy;
   assign bus.wait_ack_o      = wait_ack;
   assign bus.wait_abort_o    = wait_abort;
endmodule
`default_nettype wire

// File: tb/tb_rst_mon.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rst_mon : directed vector bench for rst_mon
// Revision   : 1.0
// ---------------------------------------------------------------------------
module tb_rst_mon;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;

   rst_mon_if #(.CNT_W(16)) bus ();

   rst_mon #(.MIN_LOW_CYCLES(100), .CNT_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int len;
      bit clr_before;
      int exp_len;
      bit exp_short;
      int exp_cnt;
   } pulse_t;

   typedef struct {
      int n;
      int exp_lat;
      bit exp_busy1;
   } wait_t;

   pulse_t ptab[6];
   wait_t  wtab[4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".in_reset"},  64'(bus.in_reset_o),      64'd0);
      chk({tag, ".low_len"},   64'(bus.low_len_o),       64'd0);
      chk({tag, ".valid"},     64'(bus.low_len_valid_o), 64'd0);
      chk({tag, ".short"},     64'(bus.short_err_o),     64'd0);
      chk({tag, ".count"},     64'(bus.rst_count_o),     64'd0);
      chk({tag, ".up"},        64'(bus.up_cycles_o),     64'd0);
      chk({tag, ".busy"},      64'(bus.wait_busy_o),     64'd0);
      chk({tag, ".ack"},       64'(bus.wait_ack_o),      64'd0);
      chk({tag, ".abort"},     64'(bus.wait_abort_o),    64'd0);
   endtask

   task automatic do_pulse(input int n);
      bus.mon_rst_ni = 1'b0;
      repeat (n) tick();
      bus.mon_rst_ni = 1'b1;
      tick();
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      bus.mon_rst_ni    = 1'b1;
      bus.clr_i         = 1'b0;
      bus.wait_req_i    = 1'b0;
      bus.wait_cycles_i = '0;

      ptab[0] = '{100, 1'b0, 100, 1'b0, 1};
      ptab[1] = '{5,   1'b0, 5,   1'b1, 2};
      ptab[2] = '{101, 1'b0, 101, 1'b1, 3};
      ptab[3] = '{100, 1'b1, 100, 1'b0, 1};
      ptab[4] = '{99,  1'b0, 99,  1'b1, 2};
      ptab[5] = '{1,   1'b0, 1,   1'b1, 3};

      wtab[0] = '{10, 10, 1'b1};
      wtab[1] = '{1,  1,  1'b0};
      wtab[2] = '{0,  1,  1'b0};
      wtab[3] = '{2,  2,  1'b1};

      // reset with junk on the inputs
      bus.mon_rst_ni = 1'b0;
      bus.wait_req_i = 1'b1;
      bus.wait_cycles_i = 16'd4;
      tick();
      tick();
      chk_zero("reset");
      bus.mon_rst_ni = 1'b1;
      bus.wait_req_i = 1'b0;
      rst_n = 1'b1;
      repeat (5) tick();
      chk("up_after_5", 64'(bus.up_cycles_o), 64'd5);

      for (int i = 0; i < 6; i++) begin
         if (ptab[i].clr_before) begin
            bus.clr_i = 1'b1;
            tick();
            bus.clr_i = 1'b0;
            chk($sformatf("p%0d.clr_short", i), 64'(bus.short_err_o), 64'd0);
            chk($sformatf("p%0d.clr_count", i), 64'(bus.rst_count_o), 64'd0);
         end
         bus.mon_rst_ni = 1'b0;
         repeat (ptab[i].len) tick();
         chk($sformatf("p%0d.in_reset_low", i), 64'(bus.in_reset_o), 64'd1);
         bus.mon_rst_ni = 1'b1;
         tick();
         chk($sformatf("p%0d.valid", i),    64'(bus.low_len_valid_o), 64'd1);
         chk($sformatf("p%0d.len", i),      64'(bus.low_len_o),       64'(ptab[i].exp_len));
         chk($sformatf("p%0d.short", i),    64'(bus.short_err_o),     64'(ptab[i].exp_short));
         chk($sformatf("p%0d.count", i),    64'(bus.rst_count_o),     64'(ptab[i].exp_cnt));
         chk($sformatf("p%0d.up0", i),      64'(bus.up_cycles_o),     64'd0);
         chk($sformatf("p%0d.in_reset", i), 64'(bus.in_reset_o),      64'd0);
         tick();
         chk($sformatf("p%0d.valid_off", i), 64'(bus.low_len_valid_o), 64'd0);
         chk($sformatf("p%0d.up1", i),       64'(bus.up_cycles_o),     64'd1);
      end

      // clr in the release cycle: set and increment win
      bus.mon_rst_ni = 1'b0;
      repeat (5) tick();
      bus.mon_rst_ni = 1'b1;
      bus.clr_i = 1'b1;
      tick();
      bus.clr_i = 1'b0;
      chk("clr_vs_rel.short", 64'(bus.short_err_o), 64'd1);
      chk("clr_vs_rel.count", 64'(bus.rst_count_o), 64'd4);
      bus.clr_i = 1'b1;
      tick();
      bus.clr_i = 1'b0;
      chk("clr.short", 64'(bus.short_err_o), 64'd0);
      chk("clr.count", 64'(bus.rst_count_o), 64'd0);

      for (int i = 0; i < 4; i++) begin
         bus.wait_req_i = 1'b1;
         bus.wait_cycles_i = 16'(wtab[i].n);
         tick();
         bus.wait_req_i = 1'b0;
         chk($sformatf("w%0d.busy1", i), 64'(bus.wait_busy_o), 64'(wtab[i].exp_busy1));
         k = 1;
         while (!bus.wait_ack_o && k < 64) begin
            tick();
            k++;
         end
         chk($sformatf("w%0d.latency", i), 64'(k), 64'(wtab[i].exp_lat));
         chk($sformatf("w%0d.abort", i),   64'(bus.wait_abort_o), 64'd0);
         chk($sformatf("w%0d.busy_ack", i), 64'(bus.wait_busy_o), 64'd0);
         tick();
      end

      // back-to-back: second request in the ack cycle
      bus.wait_req_i = 1'b1;
      bus.wait_cycles_i = 16'd10;
      tick();
      bus.wait_req_i = 1'b0;
      repeat (8) tick();
      chk("b2b.no_early_ack", 64'(bus.wait_ack_o), 64'd0);
      tick();
      chk("b2b.ack1", 64'(bus.wait_ack_o), 64'd1);
      bus.wait_req_i = 1'b1;
      bus.wait_cycles_i = 16'd3;
      tick();
      bus.wait_req_i = 1'b0;
      chk("b2b.busy2", 64'(bus.wait_busy_o), 64'd1);
      repeat (2) tick();
      chk("b2b.ack2", 64'(bus.wait_ack_o), 64'd1);
      chk("b2b.abort2", 64'(bus.wait_abort_o), 64'd0);
      tick();

      // observed reset at t+7 aborts a 20-cycle wait
      bus.wait_req_i = 1'b1;
      bus.wait_cycles_i = 16'd20;
      tick();
      bus.wait_req_i = 1'b0;
      repeat (6) tick();
      chk("abort.pre_ack", 64'(bus.wait_ack_o), 64'd0);
      bus.mon_rst_ni = 1'b0;
      tick();
      chk("abort.ack", 64'(bus.wait_ack_o), 64'd1);
      chk("abort.abort", 64'(bus.wait_abort_o), 64'd1);
      chk("abort.in_reset", 64'(bus.in_reset_o), 64'd1);
      chk("abort.busy", 64'(bus.wait_busy_o), 64'd0);

      // request while observed reset is low: immediate abort
      bus.wait_req_i = 1'b1;
      bus.wait_cycles_i = 16'd5;
      tick();
      bus.wait_req_i = 1'b0;
      chk("imm.ack", 64'(bus.wait_ack_o), 64'd1);
      chk("imm.abort", 64'(bus.wait_abort_o), 64'd1);
      chk("imm.busy", 64'(bus.wait_busy_o), 64'd0);
      bus.mon_rst_ni = 1'b1;
      tick();

      // saturation of the length counter and the pulse count
      bus.clr_i = 1'b1;
      tick();
      bus.clr_i = 1'b0;
      do_pulse(70000);
      chk("sat.len", 64'(bus.low_len_o), 64'd65535);
      chk("sat.short", 64'(bus.short_err_o), 64'd0);
      for (int i = 0; i < 299; i++) do_pulse(1);
      tick();
      chk("sat.count", 64'(bus.rst_count_o), 64'd255);

      // block reset during an active wait plus an observed low pulse
      bus.wait_req_i = 1'b1;
      bus.wait_cycles_i = 16'd20;
      tick();
      bus.wait_req_i = 1'b0;
      repeat (2) tick();
      bus.mon_rst_ni = 1'b0;
      rst_n = 1'b0;
      tick();
      chk_zero("rst_mid");
      rst_n = 1'b1;
      repeat (3) tick();
      chk("rst_mid.no_ack", 64'(bus.wait_ack_o), 64'd0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      bus.mon_rst_ni = 1'b1;
      tick();
      chk("rst_mid.no_valid", 64'(bus.low_len_valid_o), 64'd0);
      chk("rst_mid.count", 64'(bus.rst_count_o), 64'd0);
      chk("rst_mid.in_reset", 64'(bus.in_reset_o), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/rst_mon.md
RST_MON -- requirements
Module: rst_mon

Interface
REQ-001 Parameter MIN_LOW_CYCLES, default 100, minimum legal observed reset-low duration in clock cycles.
REQ-002 Parameter CNT_W, default 16, width of low-duration counter and wait-cycle counter.
REQ-003 clk  input  1  sole clock; all flops on posedge clk.
REQ-004 rst_n  input  1  synchronous active-low reset of this block.
REQ-005 mon_rst_ni  input  1  observed active-low reset, synchronous to clk.
REQ-006 clr_i  input  1  clears sticky error and event count.
REQ-007 wait_req_i  input  1  request to wait a number of clocks.
REQ-008 wait_cycles_i  input  CNT_W  cycles to wait, sampled on acceptance.
REQ-009 in_reset_o  output  1  high while observed reset held low.
REQ-010 low_len_o  output  CNT_W  length of last completed reset-low pulse.
REQ-011 low_len_valid_o  output  1  one-cycle pulse when low_len_o updates.
REQ-012 short_err_o  output  1  sticky: a reset pulse shorter than MIN_LOW_CYCLES seen.
REQ-013 rst_count_o  output  8  completed reset pulses, saturating.
REQ-014 up_cycles_o  output  32  cycles since last reset release, saturating.
REQ-015 wait_busy_o  output  1  wait in progress.
REQ-016 wait_ack_o  output  1  one-cycle pulse at wait completion or abort.
REQ-017 wait_abort_o  output  1  qualifies wait_ack_o; high when wait ended by observed reset.

Function
REQ-018 FSM states S_UP, S_LOW; S_UP when rst_n low.
REQ-019 S_UP, mon_rst_ni=0: -> S_LOW, low counter <= 1.
REQ-020 S_LOW, mon_rst_ni=0: stay; low counter +1, saturating at 2^CNT_W-1.
REQ-021 S_LOW, mon_rst_ni=1: -> S_UP; next cycle low_len_o=low counter, low_len_valid_o=1, rst_count_o +1 (saturate 255), up_cycles_o=0.
REQ-022 Release with low counter < MIN_LOW_CYCLES: short_err_o set next cycle, held until clr_i or rst_n.
REQ-023 in_reset_o registered: equals (state==S_LOW).
REQ-024 up_cycles_o increments every cycle in S_UP except release cycle, saturates at 2^32-1, holds in S_LOW.
REQ-025 clr_i zeroes short_err_o, rst_count_o; same-cycle set/increment wins over clr_i.
REQ-026 Wait accepted when wait_req_i=1 and wait_busy_o=0; wait_busy_o=1 next cycle; request ignored while busy.
REQ-027 Accepted at cycle t with N=wait_cycles_i: wait_ack_o=1 at cycle t+N, busy low same cycle; N=0 treated as N=1.
REQ-028 New request accepted in the cycle wait_ack_o is high (back-to-back allowed).
REQ-029 Busy and mon_rst_ni=0 sampled: next cycle wait_ack_o=1, wait_abort_o=1, busy=0; abort wins over normal completion in the same cycle.
REQ-030 Wait requests with mon_rst_ni=0 accepted only as immediate abort (ack+abort next cycle).

Reset
REQ-031 rst_n=0 for one clk: state S_UP, in_reset_o=0, low_len_o=0, low_len_valid_o=0, short_err_o=0, rst_count_o=0, up_cycles_o=0, wait_busy_o=0, wait_ack_o=0, wait_abort_o=0.
REQ-032 rst_n asserted mid-pulse or mid-wait discards progress; no ack, no low_len_valid_o emitted.

Verification
REQ-033 mon_rst_ni low 100 cycles then high -> low_len_valid_o pulse, low_len_o=100, rst_count_o=1, short_err_o=0, up_cycles_o restarts at 0.
REQ-034 mon_rst_ni low 5 cycles -> low_len_o=5, short_err_o=1; clr_i pulse -> short_err_o=0, rst_count_o=0.
REQ-035 wait_req_i with wait_cycles_i=10 at cycle t -> wait_ack_o=1 only at t+10, wait_abort_o=0; second request at t+10 accepted.
REQ-036 wait_cycles_i=20, mon_rst_ni low at t+7 -> wait_ack_o=wait_abort_o=1 at t+8, in_reset_o=1 at t+8.
REQ-037 mon_rst_ni held low 70000 cycles (CNT_W=16) -> low_len_o=65535; 300 pulses -> rst_count_o=255.
REQ-038 rst_n asserted during active wait and low pulse -> all outputs zero next cycle, no ack.
